// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_pkg: per-axis video timing description and helpers.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_timing_pkg;

   typedef struct packed {
      logic [15:0] h_active;
      logic [15:0] h_fp;
      logic [15:0] h_sync;
      logic [15:0] h_bp;
      logic [15:0] v_active;
      logic [15:0] v_fp;
      logic [15:0] v_sync;
      logic [15:0] v_bp;
   } timing_t;

   localparam timing_t TIMING_1600x1200 = '{
      h_active: 16'd1600, h_fp: 16'd64, h_sync: 16'd192, h_bp: 16'd304,
      v_active: 16'd1200, v_fp: 16'd1,  v_sync: 16'd3,   v_bp: 16'd46};

   localparam timing_t TIMING_640x480 = '{
      h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
      v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33};

   function automatic int unsigned h_total(input timing_t t);
      return 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
   endfunction

   function automatic int unsigned v_total(input timing_t t);
      return 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
   endfunction

   function automatic int unsigned hs_start(input timing_t t);
      return 32'(t.h_active) + 32'(t.h_fp);
   endfunction

   function automatic int unsigned vs_start(input timing_t t);
      return 32'(t.v_active) + 32'(t.v_fp);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_axis_decode: active/sync window decode for one timing axis.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_axis_decode #(
   parameter int CW = 12
) (
   input  logic [CW-1:0] pos,
   input  logic [CW-1:0] active,
   input  logic [CW-1:0] sync_start,
   input  logic [CW-1:0] sync_len,
   output logic          in_active,
   output logic          in_sync
);

   // Offset compare stays correct even when the sync end equals 2**CW.
   logic [CW-1:0] w_off;

   assign w_off     = pos - sync_start;
   assign in_active = (pos < active);
   assign in_sync   = (w_off < sync_len);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_gen: two-mode VGA timing with pixel divider and fully  |
// | registered, aligned outputs. Rev 1.0                              |
// +------------------------------------------------------------------+
module vga_timing_gen import vga_timing_pkg::*; #(
   parameter int          CW          = 12,
   parameter int          PIX_DIV     = 1,
   parameter int unsigned M0_H_ACTIVE = 32'(TIMING_1600x1200.h_active),
   parameter int unsigned M0_H_FP     = 32'(TIMING_1600x1200.h_fp),
   parameter int unsigned M0_H_SYNC   = 32'(TIMING_1600x1200.h_sync),
   parameter int unsigned M0_H_BP     = 32'(TIMING_1600x1200.h_bp),
   parameter int unsigned M0_V_ACTIVE = 32'(TIMING_1600x1200.v_active),
   parameter int unsigned M0_V_FP     = 32'(TIMING_1600x1200.v_fp),
   parameter int unsigned M0_V_SYNC   = 32'(TIMING_1600x1200.v_sync),
   parameter int unsigned M0_V_BP     = 32'(TIMING_1600x1200.v_bp),
   parameter int unsigned M1_H_ACTIVE = 32'(TIMING_640x480.h_active),
   parameter int unsigned M1_H_FP     = 32'(TIMING_640x480.h_fp),
   parameter int unsigned M1_H_SYNC   = 32'(TIMING_640x480.h_sync),
   parameter int unsigned M1_H_BP     = 32'(TIMING_640x480.h_bp),
   parameter int unsigned M1_V_ACTIVE = 32'(TIMING_640x480.v_active),
   parameter int unsigned M1_V_FP     = 32'(TIMING_640x480.v_fp),
   parameter int unsigned M1_V_SYNC   = 32'(TIMING_640x480.v_sync),
   parameter int unsigned M1_V_BP     = 32'(TIMING_640x480.v_bp),
   parameter logic        HS_POL      = 1'b0,
   parameter logic        VS_POL      = 1'b0
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          mode_sel,
   output logic          hs,
   output logic          vs,
   output logic          blank,
   output logic          sync,
   output logic [CW-1:0] DrawX,
   output logic [CW-1:0] DrawY,
   output logic          pix_en,
   output logic          line_start,
   output logic          frame_start,
   output logic          mode_active
);

   localparam timing_t c_m0 = '{
      h_active: 16'(M0_H_ACTIVE), h_fp: 16'(M0_H_FP), h_sync: 16'(M0_H_SYNC), h_bp: 16'(M0_H_BP),
      v_active: 16'(M0_V_ACTIVE), v_fp: 16'(M0_V_FP), v_sync: 16'(M0_V_SYNC), v_bp: 16'(M0_V_BP)};
   localparam timing_t c_m1 = '{
      h_active: 16'(M1_H_ACTIVE), h_fp: 16'(M1_H_FP), h_sync: 16'(M1_H_SYNC), h_bp: 16'(M1_H_BP),
      v_active: 16'(M1_V_ACTIVE), v_fp: 16'(M1_V_FP), v_sync: 16'(M1_V_SYNC), v_bp: 16'(M1_V_BP)};

   localparam int unsigned c_lim = 32'(1) << CW;
   localparam int          c_dw  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   generate
      if (h_total(c_m0) > c_lim || v_total(c_m0) > c_lim ||
          h_total(c_m1) > c_lim || v_total(c_m1) > c_lim) begin : g_err_total
         $error("vga_timing_gen: timing total does not fit in CW bits");
      end
      if (M0_H_ACTIVE == 0 || M0_H_SYNC == 0 || M0_V_ACTIVE == 0 || M0_V_SYNC == 0 ||
          M1_H_ACTIVE == 0 || M1_H_SYNC == 0 || M1_V_ACTIVE == 0 || M1_V_SYNC == 0) begin : g_err_zero
         $error("vga_timing_gen: active and sync widths must be non-zero");
      end
      if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_err_div
         $error("vga_timing_gen: PIX_DIV must be 1..16");
      end
   endgenerate

   localparam logic [CW-1:0] c_m0_hlast = CW'(h_total(c_m0) - 1);
   localparam logic [CW-1:0] c_m0_vlast = CW'(v_total(c_m0) - 1);
   localparam logic [CW-1:0] c_m1_hlast = CW'(h_total(c_m1) - 1);
   localparam logic [CW-1:0] c_m1_vlast = CW'(v_total(c_m1) - 1);
   localparam logic [c_dw-1:0] c_div_last = c_dw'(PIX_DIV - 1);

   logic [c_dw-1:0] r_div;
   logic [CW-1:0]   r_hc, r_vc;
   logic            r_mode;
   logic            w_tick;
   logic [CW-1:0]   w_hlast, w_vlast;
   logic [CW-1:0]   w_h_act, w_h_ss, w_h_sl, w_v_act, w_v_ss, w_v_sl;
   logic            w_h_in_act, w_h_in_sync, w_v_in_act, w_v_in_sync;

   logic            r_hs, r_vs, r_blank, r_pix_en, r_line, r_frame;
   logic [CW-1:0]   r_x, r_y;

   assign w_tick  = (r_div == c_div_last);
   assign w_hlast = r_mode ? c_m1_hlast : c_m0_hlast;
   assign w_vlast = r_mode ? c_m1_vlast : c_m0_vlast;
   assign w_h_act = r_mode ? CW'(M1_H_ACTIVE)    : CW'(M0_H_ACTIVE);
   assign w_h_ss  = r_mode ? CW'(hs_start(c_m1)) : CW'(hs_start(c_m0));
   assign w_h_sl  = r_mode ? CW'(M1_H_SYNC)      : CW'(M0_H_SYNC);
   assign w_v_act = r_mode ? CW'(M1_V_ACTIVE)    : CW'(M0_V_ACTIVE);
   assign w_v_ss  = r_mode ? CW'(vs_start(c_m1)) : CW'(vs_start(c_m0));
   assign w_v_sl  = r_mode ? CW'(M1_V_SYNC)      : CW'(M0_V_SYNC);

   vga_axis_decode #(.CW(CW)) u_h_decode (
      .pos(r_hc), .active(w_h_act), .sync_start(w_h_ss), .sync_len(w_h_sl),
      .in_active(w_h_in_act), .in_sync(w_h_in_sync));

   vga_axis_decode #(.CW(CW)) u_v_decode (
      .pos(r_vc), .active(w_v_act), .sync_start(w_v_ss), .sync_len(w_v_sl),
      .in_active(w_v_in_act), .in_sync(w_v_in_sync));

   // Mode is only sampled on the frame-end tick, when both counters wrap to 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_div  <= '0;
         r_hc   <= '0;
         r_vc   <= '0;
         r_mode <= 1'b0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            if (r_hc == w_hlast) begin
               r_hc <= '0;
               if (r_vc == w_vlast) begin
                  r_vc   <= '0;
                  r_mode <= mode_sel;
               end else begin
                  r_vc <= r_vc + 1'b1;
               end
            end else begin
               r_hc <= r_hc + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_hs     <= ~HS_POL;
         r_vs     <= ~VS_POL;
         r_blank  <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_pix_en <= 1'b0;
         r_line   <= 1'b0;
         r_frame  <= 1'b0;
      end else begin
         r_pix_en <= w_tick;
         r_line   <= w_tick && (r_hc == '0);
         r_frame  <= w_tick && (r_hc == '0) && (r_vc == '0);
         if (w_tick) begin
            r_x     <= r_hc;
            r_y     <= r_vc;
            r_blank <= w_h_in_act && w_v_in_act;
            r_hs    <= w_h_in_sync ? HS_POL : ~HS_POL;
            r_vs    <= w_v_in_sync ? VS_POL : ~VS_POL;
         end
      end
   end

   assign hs          = r_hs;
   assign vs          = r_vs;
   assign blank       = r_blank;
   assign sync        = 1'b0;
   assign DrawX       = r_x;
   assign DrawY       = r_y;
   assign pix_en      = r_pix_en;
   assign line_start  = r_line;
   assign frame_start = r_frame;
   assign mode_active = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_timing_gen: randomized mode/reset stimulus against a       |
// | frame-index reference model. Rev 1.0                              |
// +------------------------------------------------------------------+
module tb_vga_timing_gen;

   localparam int   CW      = 6;
   localparam int   PIX_DIV = 3;
   localparam logic HS_POL  = 1'b0;
   localparam logic VS_POL  = 1'b1;
   localparam int   NCYC    = 20000;

   // Small geometries keep several full frames of each mode within budget.
   int ha[2] = '{12, 8};
   int hf[2] = '{2, 1};
   int hsw[2] = '{3, 2};
   int hb[2] = '{4, 3};
   int va[2] = '{6, 4};
   int vf[2] = '{1, 2};
   int vsw[2] = '{2, 1};
   int vb[2] = '{2, 1};

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          mode_sel = 1'b0;
   logic          hs, vs, blank, sync, pix_en, line_start, frame_start, mode_active;
   logic [CW-1:0] DrawX, DrawY;

   int n_checks = 0;
   int n_errors = 0;

   int m_phase, m_idx, m_mode;
   logic e_hs, e_vs, e_blank, e_pix, e_line, e_frame;
   int e_x, e_y;

   vga_timing_gen #(
      .CW(CW), .PIX_DIV(PIX_DIV),
      .M0_H_ACTIVE(12), .M0_H_FP(2), .M0_H_SYNC(3), .M0_H_BP(4),
      .M0_V_ACTIVE(6),  .M0_V_FP(1), .M0_V_SYNC(2), .M0_V_BP(2),
      .M1_H_ACTIVE(8),  .M1_H_FP(1), .M1_H_SYNC(2), .M1_H_BP(3),
      .M1_V_ACTIVE(4),  .M1_V_FP(2), .M1_V_SYNC(1), .M1_V_BP(1),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .mode_sel(mode_sel),
      .hs(hs), .vs(vs), .blank(blank), .sync(sync),
      .DrawX(DrawX), .DrawY(DrawY), .pix_en(pix_en),
      .line_start(line_start), .frame_start(frame_start),
      .mode_active(mode_active)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_idx = 0; m_mode = 0;
      e_hs = ~HS_POL; e_vs = ~VS_POL; e_blank = 1'b0;
      e_x = 0; e_y = 0; e_pix = 1'b0; e_line = 1'b0; e_frame = 1'b0;
   endtask

   // One rising edge with reset released: pixel idx of the frame becomes visible on a tick.
   task automatic model_step();
      int htot, vtot, x, y;
      bit tick;
      tick    = (m_phase == PIX_DIV - 1);
      m_phase = tick ? 0 : m_phase + 1;
      e_pix   = tick;
      e_line  = 1'b0;
      e_frame = 1'b0;
      if (tick) begin
         htot    = ha[m_mode] + hf[m_mode] + hsw[m_mode] + hb[m_mode];
         vtot    = va[m_mode] + vf[m_mode] + vsw[m_mode] + vb[m_mode];
         x       = m_idx % htot;
         y       = m_idx / htot;
         e_x     = x;
         e_y     = y;
         e_blank = (x < ha[m_mode]) && (y < va[m_mode]);
         e_hs    = (x >= ha[m_mode] + hf[m_mode] && x < ha[m_mode] + hf[m_mode] + hsw[m_mode])
                   ? HS_POL : ~HS_POL;
         e_vs    = (y >= va[m_mode] + vf[m_mode] && y < va[m_mode] + vf[m_mode] + vsw[m_mode])
                   ? VS_POL : ~VS_POL;
         e_line  = (x == 0);
         e_frame = (m_idx == 0);
         if (m_idx == htot * vtot - 1) begin
            m_idx  = 0;
            m_mode = int'(mode_sel);
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("hs",          32'(hs),          32'(e_hs));
      check_val("vs",          32'(vs),          32'(e_vs));
      check_val("blank",       32'(blank),       32'(e_blank));
      check_val("sync",        32'(sync),        32'd0);
      check_val("DrawX",       32'(DrawX),       32'(e_x));
      check_val("DrawY",       32'(DrawY),       32'(e_y));
      check_val("pix_en",      32'(pix_en),      32'(e_pix));
      check_val("line_start",  32'(line_start),  32'(e_line));
      check_val("frame_start", 32'(frame_start), 32'(e_frame));
      check_val("mode_active", 32'(mode_active), 32'(m_mode));
   endtask

   initial begin
      int rst_hold;
      model_reset();
      rst_hold = 5;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge Clk);
         check_outputs();
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) Reset_n = 1'b1;
         end else if ($urandom_range(0, 2999) == 0 || cyc == 9001) begin
            Reset_n  = 1'b0;
            rst_hold = $urandom_range(1, 3);
            #1;
            model_reset();
            check_outputs();
         end
         if ($urandom_range(0, 399) == 0) mode_sel = ~mode_sel;
         @(posedge Clk);
         if (Reset_n) model_step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
